sim_mem_multiport: RTL and testbench

//  Parametrised multi-port memory model for multicore SoC benches: NUM_PORTS independent

---
 rtl/sim_mem_multiport.sv | 162 ++++++++++++++++
 tb/tb_sim_mem_multiport.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sim_mem_multiport.sv
// sim_mem_multiport
//   Multi-port word-organised memory model for multicore SoC benches. NUM_PORTS
//   requesters share one array through a round-robin arbiter (one grant per cycle).
//   Each accepted request returns exactly one response LATENCY cycles later through
//   a tagged pipeline. Out-of-window or misaligned accesses return an error response
//   and leave the array untouched.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset (array contents are kept)
//   req_valid   per-port request valid
//   req_ready   per-port grant; request accepted when valid & ready
//   req_write   per-port 1 = write, 0 = read
//   req_addr    per-port byte address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata   per-port write data
//   req_be      per-port byte enables, bit i -> byte i
//   resp_valid  per-port one-cycle response pulse
//   resp_rdata  per-port read data (0 for writes and errors)
//   resp_error  per-port error flag
//   err_count   saturating count of error responses
module sim_mem_multiport #(
  parameter int                    NUM_PORTS  = 4,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DEPTH      = 8192,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000,
  parameter int                    LATENCY    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] req_be,
  output logic [NUM_PORTS-1:0]             resp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  resp_rdata,
  output logic [NUM_PORTS-1:0]             resp_error,
  output logic [31:0]                      err_count
);

  localparam int BE_W   = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BE_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES  = ADDR_WIDTH'(DEPTH * BE_W);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BE_W - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PORT_W-1:0]     rr_ptr;
  logic [PORT_W-1:0]     grant_idx;
  logic                  grant_found;
  logic [NUM_PORTS-1:0]  grant;
  logic                  accept;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [ADDR_WIDTH-1:0] sel_offset;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BE_W-1:0]       sel_be;
  logic                  sel_write;
  logic                  acc_error;
  logic [IDX_W-1:0]      acc_index;

  logic [LATENCY-1:0]    pipe_valid;
  logic [LATENCY-1:0]    pipe_error;
  logic [PORT_W-1:0]     pipe_port  [LATENCY];
  logic [DATA_WIDTH-1:0] pipe_rdata [LATENCY];

  // Round-robin search starting at rr_ptr; the first valid port wins. Reset
  // suppresses the grant so nothing is accepted while rst is high.
  always_comb begin : arbiter
    int                cand;
    logic [PORT_W-1:0] cand_idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant       = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = PORT_W'(cand);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
    if (grant_found && !rst) grant[grant_idx] = 1'b1;
  end

  assign req_ready = grant;
  assign accept    = grant_found & ~rst;

  assign sel_addr   = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata  = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign sel_be     = req_be[grant_idx*BE_W +: BE_W];
  assign sel_write  = req_write[grant_idx];
  assign sel_offset = sel_addr - BASE_ADDR;

  // The upper-bound test is on the offset, which is only meaningful once the
  // address is known to be at or above the base, so it cannot wrap.
  assign acc_error = (sel_addr < BASE_ADDR) || (sel_offset >= MEM_BYTES) ||
                     ((sel_addr & ALIGN_MASK) != '0);
  assign acc_index = sel_offset[OFF_W +: IDX_W];

  // Byte-enabled array write on the accept edge; error accesses never touch it.
  always_ff @(posedge clk) begin
    if (accept && sel_write && !acc_error) begin
      for (int b = 0; b < BE_W; b++) begin
        if (sel_be[b]) mem[acc_index][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  // Arbiter pointer, response pipeline and error counter. Stage 0 captures the
  // accepted request (read data sampled from the array before this edge's write
  // lands); the last stage drives the response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr     <= '0;
      pipe_valid <= '0;
      pipe_error <= '0;
      err_count  <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_port[i]  <= '0;
        pipe_rdata[i] <= '0;
      end
    end else begin
      if (accept) begin
        rr_ptr <= (grant_idx == PORT_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
      end
      pipe_valid[0] <= accept;
      pipe_port[0]  <= grant_idx;
      pipe_error[0] <= accept & acc_error;
      pipe_rdata[0] <= (accept && !sel_write && !acc_error) ? mem[acc_index] : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_port[i]  <= pipe_port[i-1];
        pipe_error[i] <= pipe_error[i-1];
        pipe_rdata[i] <= pipe_rdata[i-1];
      end
      if (pipe_valid[LATENCY-1] && pipe_error[LATENCY-1] && (err_count != 32'hFFFF_FFFF)) begin
        err_count <= err_count + 32'd1;
      end
    end
  end

  // Route the last pipeline stage to its owning port; all other ports read 0.
  always_comb begin
    resp_valid = '0;
    resp_error = '0;
    resp_rdata = '0;
    if (pipe_valid[LATENCY-1]) begin
      resp_valid[pipe_port[LATENCY-1]] = 1'b1;
      resp_error[pipe_port[LATENCY-1]] = pipe_error[LATENCY-1];
      resp_rdata[pipe_port[LATENCY-1]*DATA_WIDTH +: DATA_WIDTH] = pipe_rdata[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_sim_mem_multiport.sv
// tb_sim_mem_multiport
//   Directed bench for sim_mem_multiport. Three instances with LATENCY 2, 1 and 5
//   share the same request inputs; arbitration does not depend on latency, so the
//   instances differ only in when responses appear.
module tb_sim_mem_multiport;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_valid;
  logic [3:0]   req_write;
  logic [255:0] req_addr;
  logic [255:0] req_wdata;
  logic [31:0]  req_be;

  logic [3:0]   ready_a, ready_b, ready_c;
  logic [3:0]   rvalid_a, rvalid_b, rvalid_c;
  logic [255:0] rdata_a, rdata_b, rdata_c;
  logic [3:0]   rerr_a, rerr_b, rerr_c;
  logic [31:0]  errcnt_a, errcnt_b, errcnt_c;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [63:0] D0 = 64'h0011_2233_4455_6677;
  localparam logic [63:0] D5 = 64'hA5A5_0000_1234_5678;

  always #5 clk = ~clk;

  sim_mem_multiport #(.LATENCY(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rvalid_a), .resp_rdata(rdata_a), .resp_error(rerr_a), .err_count(errcnt_a));

  sim_mem_multiport #(.LATENCY(1)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_b),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rvalid_b), .resp_rdata(rdata_b), .resp_error(rerr_b), .err_count(errcnt_b));

  sim_mem_multiport #(.LATENCY(5)) dut_c (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_c),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rvalid_c), .resp_rdata(rdata_c), .resp_error(rerr_c), .err_count(errcnt_c));

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int port, input logic valid, input logic wr,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [7:0] be);
    req_valid[port]          = valid;
    req_write[port]          = wr;
    req_addr[port*64 +: 64]  = addr;
    req_wdata[port*64 +: 64] = wdata;
    req_be[port*8 +: 8]      = be;
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One request on one port; waits (bounded) for the grant, then watches eight
  // cycles and records the first response offset seen on each instance.
  task automatic singleAccess(input int port, input logic wr, input logic [63:0] addr,
                              input logic [63:0] wdata, input logic [7:0] be,
                              output int lat_a, output int lat_b, output int lat_c,
                              output logic [63:0] rd, output logic er);
    int waited;
    lat_a = -1; lat_b = -1; lat_c = -1; rd = 'x; er = 1'bx;
    @(negedge clk);
    applyStimulus(port, 1'b1, wr, addr, wdata, be);
    #1;
    waited = 0;
    while (!ready_a[port] && waited < 16) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("grant_seen", 64'(ready_a[port]), 64'd1);
    @(negedge clk);
    applyStimulus(port, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (rvalid_a[port] && lat_a < 0) begin
        lat_a = k;
        rd    = rdata_a[port*64 +: 64];
        er    = rerr_a[port];
      end
      if (rvalid_b[port] && lat_b < 0) lat_b = k;
      if (rvalid_c[port] && lat_c < 0) lat_c = k;
    end
  endtask

  initial begin : stimulus
    int la, lb, lc;
    logic [63:0] rd;
    logic er;
    int g;
    logic [3:0] exp_v;

    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_be = '0;

    // Reset state: even with every port requesting, nothing is granted.
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    checkOutput("reset_ready", 64'(ready_a), 64'd0);
    checkOutput("reset_resp_valid", 64'(rvalid_a), 64'd0);
    checkOutput("reset_resp_rdata", rdata_a[63:0], 64'd0);
    checkOutput("reset_err_count", 64'(errcnt_a), 64'd0);
    req_valid = 4'h0;
    @(negedge clk);
    rst = 1'b0;

    // Preload word 0, then read it back; latency per instance.
    singleAccess(0, 1'b1, 64'h8000_0000, D0, 8'hFF, la, lb, lc, rd, er);
    checkOutput("t1_write_lat", 64'(la), 64'd2);
    checkOutput("t1_write_rdata", rd, 64'd0);
    singleAccess(0, 1'b0, 64'h8000_0000, 64'd0, 8'd0, la, lb, lc, rd, er);
    checkOutput("t1_read_lat2", 64'(la), 64'd2);
    checkOutput("t1_read_lat1", 64'(lb), 64'd1);
    checkOutput("t1_read_lat5", 64'(lc), 64'd5);
    checkOutput("t1_read_rdata", rd, D0);
    checkOutput("t1_read_error", 64'(er), 64'd0);

    // Partial byte-enable write over a zeroed word.
    singleAccess(1, 1'b1, 64'h8000_0008, 64'd0, 8'hFF, la, lb, lc, rd, er);
    singleAccess(1, 1'b1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, la, lb, lc, rd, er);
    singleAccess(1, 1'b0, 64'h8000_0008, 64'd0, 8'd0, la, lb, lc, rd, er);
    checkOutput("t2_be_rdata", rd, 64'h0000_0000_FFFF_FFFF);
    checkOutput("t2_be_error", 64'(er), 64'd0);

    // All four ports request for 8 cycles right after reset: grants rotate
    // 0,1,2,3,... and each response follows its grant by the instance latency.
    resetDut();
    for (int c = 0; c <= 12; c++) begin
      @(negedge clk);
      if (c == 0) begin
        for (int p = 0; p < 4; p++)
          applyStimulus(p, 1'b1, 1'b0, 64'h8000_0000 + 64'(8*p), 64'd0, 8'd0);
      end
      if (c == 8) req_valid = 4'h0;
      #1;
      exp_v = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
      checkOutput($sformatf("t3_grant_c%0d", c), 64'(ready_a), 64'(exp_v));
      g = c - 2;
      exp_v = (g >= 0 && g < 8) ? (4'b0001 << (g % 4)) : 4'b0000;
      checkOutput($sformatf("t3_resp_l2_c%0d", c), 64'(rvalid_a), 64'(exp_v));
      g = c - 1;
      exp_v = (g >= 0 && g < 8) ? (4'b0001 << (g % 4)) : 4'b0000;
      checkOutput($sformatf("t3_resp_l1_c%0d", c), 64'(rvalid_b), 64'(exp_v));
      g = c - 5;
      exp_v = (g >= 0 && g < 8) ? (4'b0001 << (g % 4)) : 4'b0000;
      checkOutput($sformatf("t3_resp_l5_c%0d", c), 64'(rvalid_c), 64'(exp_v));
    end

    // Range and alignment errors.
    singleAccess(3, 1'b0, 64'h7FFF_FFF8, 64'd0, 8'd0, la, lb, lc, rd, er);
    checkOutput("t4_below_error", 64'(er), 64'd1);
    checkOutput("t4_below_rdata", rd, 64'd0);
    checkOutput("t4_below_lat", 64'(la), 64'd2);
    singleAccess(3, 1'b0, 64'h8001_0000, 64'd0, 8'd0, la, lb, lc, rd, er);
    checkOutput("t4_above_error", 64'(er), 64'd1);
    checkOutput("t4_above_rdata", rd, 64'd0);
    singleAccess(3, 1'b0, 64'h8000_0004, 64'd0, 8'd0, la, lb, lc, rd, er);
    checkOutput("t4_misalign_error", 64'(er), 64'd1);
    checkOutput("t4_misalign_rdata", rd, 64'd0);
    checkOutput("t4_err_count_l2", 64'(errcnt_a), 64'd3);
    checkOutput("t4_err_count_l1", 64'(errcnt_b), 64'd3);
    checkOutput("t4_err_count_l5", 64'(errcnt_c), 64'd3);
    singleAccess(0, 1'b0, 64'h8000_0000, 64'd0, 8'd0, la, lb, lc, rd, er);
    checkOutput("t4_word0_intact", rd, D0);

    // Reset mid-operation: a write plus three reads accepted back to back on port 2,
    // reset the cycle after the last accept; nothing may respond afterwards.
    @(negedge clk);
    applyStimulus(2, 1'b1, 1'b1, 64'h8000_0028, D5, 8'hFF);
    #1;
    checkOutput("t5_grant_write", 64'(ready_a[2]), 64'd1);
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      applyStimulus(2, 1'b1, 1'b0, 64'h8000_0000 + 64'(8*r), 64'd0, 8'd0);
      #1;
      checkOutput($sformatf("t5_grant_read%0d", r), 64'(ready_a[2]), 64'd1);
    end
    @(negedge clk);
    applyStimulus(2, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      #1;
      checkOutput($sformatf("t5_quiet_l2_k%0d", k), 64'(rvalid_a), 64'd0);
      checkOutput($sformatf("t5_quiet_l1_k%0d", k), 64'(rvalid_b), 64'd0);
      checkOutput($sformatf("t5_quiet_l5_k%0d", k), 64'(rvalid_c), 64'd0);
      @(negedge clk);
    end
    checkOutput("t5_err_count_cleared", 64'(errcnt_a), 64'd0);
    singleAccess(2, 1'b0, 64'h8000_0028, 64'd0, 8'd0, la, lb, lc, rd, er);
    checkOutput("t5_write_survives", rd, D5);
    checkOutput("t5_post_reset_lat", 64'(la), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
